// File: rtl/multicycle_cu.sv
// multicycle_cu: FSM control unit for the multi-cycle RV32I datapath.
// Optional retire counter output: define MULTICYCLE_CU_RETIRE_CNT_EN.
module multicycle_cu #(
  parameter int          XLEN        = 32,
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        opa_sel,
  output logic        opb_sel,
  output logic [1:0]  wb_sel,
  output logic        rf_we,
  output logic        dm_req,
  output logic        dm_we,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  func3,
  output logic        subsra,
  output logic        trap,
  output logic [2:0]  state
`ifdef MULTICYCLE_CU_RETIRE_CNT_EN
  ,
  output logic [XLEN-1:0] retired
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam int CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [31:0]   r_ir;
  logic [CW-1:0] r_cnt;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br;
  logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc;
  logic w_legal, w_addr, w_shift;
  logic w_fetch, w_exec, w_mem, w_wb;
  logic w_to_hit;
  logic w_unused_ir;

  assign w_op       = r_ir[6:0];
  assign w_f3       = r_ir[14:12];
  assign w_is_r     = (w_op == OP_R);
  assign w_is_i     = (w_op == OP_I);
  assign w_is_ld    = (w_op == OP_LD);
  assign w_is_st    = (w_op == OP_ST);
  assign w_is_br    = (w_op == OP_BR);
  assign w_is_jal   = (w_op == OP_JAL);
  assign w_is_jalr  = (w_op == OP_JALR);
  assign w_is_lui   = (w_op == OP_LUI);
  assign w_is_auipc = (w_op == OP_AUIPC);

  assign w_legal = w_is_r | w_is_i | w_is_ld | w_is_st |
                   w_is_br | w_is_jal | w_is_jalr |
                   w_is_lui | w_is_auipc;

  // ALU must add for addresses and PC-relative targets
  assign w_addr  = w_is_ld | w_is_st | w_is_br |
                   w_is_jal | w_is_jalr | w_is_auipc;
  assign w_shift = w_is_i & ((w_f3 == 3'b001) | (w_f3 == 3'b101));

  assign w_fetch = (r_state == S_FETCH);
  assign w_exec  = (r_state == S_EXEC);
  assign w_mem   = (r_state == S_MEM);
  assign w_wb    = (r_state == S_WB);

  assign w_to_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                    (r_cnt == CW'(MEM_TIMEOUT - 1));

  assign w_unused_ir = ^{r_ir[31], r_ir[29:25]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        unique case (1'b1)
          w_is_br:           w_next = S_FETCH;
          w_is_ld | w_is_st: w_next = S_MEM;
          default:           w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready)
          w_next = w_is_st ? S_FETCH : S_WB;
        else if (w_to_hit)
          w_next = S_TRAP;
      end
      S_WB:    w_next = S_FETCH;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_ir    <= NOP_INSTR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_fetch)
        r_ir <= instr;
      if (w_mem && (w_next != S_MEM))
        r_cnt <= '0;
      else if (w_mem && !mem_ready)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // strobes are gated by reset so they drop the instant it asserts
  assign ir_we  = reset & w_fetch;
  assign pc_we  = reset & ((w_exec & w_is_br) |
                           (w_mem & w_is_st & mem_ready) |
                           w_wb);
  assign rf_we  = reset & w_wb & (r_ir[11:7] != 5'd0);
  assign dm_req = reset & w_mem;
  assign dm_we  = reset & w_mem & w_is_st;

  assign pc_sel = (w_exec & w_is_br & br_taken) |
                  (w_wb & (w_is_jal | w_is_jalr));
  assign opa_sel = w_is_r | w_is_i | w_is_ld |
                   w_is_st | w_is_jalr;
  assign opb_sel = ~w_is_r;

  always_comb begin
    wb_sel = 2'b01;
    unique case (1'b1)
      w_is_ld:              wb_sel = 2'b00;
      w_is_jal | w_is_jalr: wb_sel = 2'b10;
      w_is_lui:             wb_sel = 2'b11;
      default:              wb_sel = 2'b01;
    endcase
  end

  assign rs1    = r_ir[19:15];
  assign rs2    = r_ir[24:20];
  assign rd     = r_ir[11:7];
  assign func3  = w_addr ? 3'b000 : w_f3;
  assign subsra = (w_is_r | w_shift) & r_ir[30];
  assign trap   = (r_state == S_TRAP);
  assign state  = r_state;

`ifdef MULTICYCLE_CU_RETIRE_CNT_EN
  logic [XLEN-1:0] r_retired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_retired <= '0;
    else if (pc_we)
      r_retired <= r_retired + 1'b1;
  end

  assign retired = r_retired;
`else
  logic [XLEN-1:0] w_unused_xlen;
  assign w_unused_xlen = '0;
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// tb_multicycle_cu: per-cycle schedule model of multicycle_cu.
// Directed test-plan cases followed by randomized instructions.
module tb_multicycle_cu;

  localparam logic [31:0] NOP = 32'h00000013;

  localparam int C_R    = 0;
  localparam int C_I    = 1;
  localparam int C_LD   = 2;
  localparam int C_ST   = 3;
  localparam int C_BR   = 4;
  localparam int C_JAL  = 5;
  localparam int C_JALR = 6;
  localparam int C_LUI  = 7;
  localparam int C_AUI  = 8;
  localparam int C_BAD  = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_we, pc_we, pc_sel, opa_sel, opb_sel;
  logic        rf_we, dm_req, dm_we, subsra, trap;
  logic [1:0]  wb_sel;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  func3, state;
`ifdef MULTICYCLE_CU_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  multicycle_cu #(
    .XLEN(32),
    .MEM_TIMEOUT(15),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .br_taken(br_taken),
    .mem_ready(mem_ready),
    .ir_we(ir_we),
    .pc_we(pc_we),
    .pc_sel(pc_sel),
    .opa_sel(opa_sel),
    .opb_sel(opb_sel),
    .wb_sel(wb_sel),
    .rf_we(rf_we),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .rs1(rs1),
    .rs2(rs2),
    .rd(rd),
    .func3(func3),
    .subsra(subsra),
    .trap(trap),
    .state(state)
`ifdef MULTICYCLE_CU_RETIRE_CNT_EN
    ,
    .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        br;
    logic        mrdy;
    logic [2:0]  st;
    logic [31:0] ir;
    logic        chk;
    logic        ir_we;
    logic        pc_we;
    logic        pc_sel;
    logic        rf_we;
    logic        dm_req;
    logic        dm_we;
    logic        trp;
  } rec_t;

  rec_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic int cls_of(logic [31:0] ir);
    case (ir[6:0])
      7'h33:   return C_R;
      7'h13:   return C_I;
      7'h03:   return C_LD;
      7'h23:   return C_ST;
      7'h63:   return C_BR;
      7'h6F:   return C_JAL;
      7'h67:   return C_JALR;
      7'h37:   return C_LUI;
      7'h17:   return C_AUI;
      default: return C_BAD;
    endcase
  endfunction

  task automatic chk(input int cyc, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic rec_t mk(logic [2:0] st, logic [31:0] ir);
    rec_t r;
    r.rst    = 1'b1;
    r.instr  = $urandom;
    r.br     = 1'($urandom);
    r.mrdy   = 1'($urandom);
    r.st     = st;
    r.ir     = ir;
    r.chk    = 1'b1;
    r.ir_we  = 1'b0;
    r.pc_we  = 1'b0;
    r.pc_sel = 1'b0;
    r.rf_we  = 1'b0;
    r.dm_req = 1'b0;
    r.dm_we  = 1'b0;
    r.trp    = 1'b0;
    return r;
  endfunction

  task automatic push_rst();
    rec_t r;
    r = mk(3'd0, NOP);
    r.rst = 1'b0;
    q.push_back(r);
  endtask

  task automatic push_trap(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = mk(3'd7, 32'h0);
      r.chk = 1'b0;
      r.trp = 1'b1;
      q.push_back(r);
    end
    push_rst();
  endtask

  // Expected cycle-by-cycle schedule of one instruction.
  task automatic add_instr(input logic [31:0] ir, input int w,
                           input logic b, input int rst_at,
                           input int ntrap);
    int   c;
    rec_t r;
    c = cls_of(ir);
    r = mk(3'd0, ir);
    r.instr = ir;
    r.chk = 1'b0;
    r.ir_we = 1'b1;
    q.push_back(r);
    r = mk(3'd1, ir);
    r.chk = (c != C_BAD);
    q.push_back(r);
    if (c == C_BAD) begin
      push_trap(ntrap);
      return;
    end
    r = mk(3'd2, ir);
    if (c == C_BR) begin
      r.br = b;
      r.pc_we = 1'b1;
      r.pc_sel = b;
      q.push_back(r);
      return;
    end
    q.push_back(r);
    if (c == C_LD || c == C_ST) begin
      for (int k = 0; k < 15; k++) begin
        if (k == rst_at) begin
          push_rst();
          return;
        end
        r = mk(3'd3, ir);
        r.dm_req = 1'b1;
        r.dm_we = (c == C_ST);
        r.mrdy = (k == w);
        if (k == w && c == C_ST) begin
          r.pc_we = 1'b1;
          r.pc_sel = 1'b0;
        end
        q.push_back(r);
        if (k == w) break;
        if (k == 14) begin
          push_trap(ntrap);
          return;
        end
      end
      if (c == C_ST) return;
    end
    r = mk(3'd4, ir);
    r.rf_we = (ir[11:7] != 5'd0);
    r.pc_we = 1'b1;
    r.pc_sel = (c == C_JAL || c == C_JALR);
    q.push_back(r);
  endtask

  initial begin : cmp
    rec_t        r;
    int          c;
    int          cyc;
    logic [1:0]  ewb;
    logic [2:0]  ef3;
    logic [31:0] exp_ret;
    cyc = 0;
    exp_ret = 0;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        r = q.pop_front();
        reset = r.rst;
        instr = r.instr;
        br_taken = r.br;
        mem_ready = r.mrdy;
        #1;
        cyc++;
        chk(cyc, "state", state, r.st);
        chk(cyc, "ir_we", ir_we, r.ir_we);
        chk(cyc, "pc_we", pc_we, r.pc_we);
        chk(cyc, "rf_we", rf_we, r.rf_we);
        chk(cyc, "dm_req", dm_req, r.dm_req);
        chk(cyc, "dm_we", dm_we, r.dm_we);
        chk(cyc, "trap", trap, r.trp);
        if (r.pc_we) chk(cyc, "pc_sel", pc_sel, r.pc_sel);
        if (r.chk) begin
          c = cls_of(r.ir);
          chk(cyc, "rs1", rs1, r.ir[19:15]);
          chk(cyc, "rs2", rs2, r.ir[24:20]);
          chk(cyc, "rd", rd, r.ir[11:7]);
          chk(cyc, "opa_sel", opa_sel,
              (c == C_R || c == C_I || c == C_LD ||
               c == C_ST || c == C_JALR));
          chk(cyc, "opb_sel", opb_sel, (c != C_R));
          ef3 = (c == C_R || c == C_I || c == C_LUI) ?
                r.ir[14:12] : 3'b000;
          chk(cyc, "func3", func3, ef3);
          chk(cyc, "subsra", subsra,
              (c == C_R || (c == C_I &&
               (r.ir[14:12] == 3'd1 || r.ir[14:12] == 3'd5)))
              ? r.ir[30] : 1'b0);
          if (c != C_ST && c != C_BR) begin
            case (c)
              C_LD:           ewb = 2'b00;
              C_JAL, C_JALR:  ewb = 2'b10;
              C_LUI:          ewb = 2'b11;
              default:        ewb = 2'b01;
            endcase
            chk(cyc, "wb_sel", wb_sel, ewb);
          end
        end
`ifdef MULTICYCLE_CU_RETIRE_CNT_EN
        if (!r.rst) exp_ret = 0;
        chk(cyc, "retired", retired, exp_ret);
        if (r.rst && r.pc_we) exp_ret = exp_ret + 1;
`endif
      end
    end
  end

  initial begin : stim
    int          n;
    int          guard;
    int          sel;
    int          w;
    int          ra;
    logic [31:0] ir;
    push_rst();
    n = q.size();
    add_instr(32'h002081B3, 0, 1'b0, -1, 3);
    chk(0, "len_add", q.size() - n, 4);
    n = q.size();
    add_instr(32'h0080A283, 2, 1'b0, -1, 3);
    chk(0, "len_lw_w2", q.size() - n, 7);
    n = q.size();
    add_instr(32'h00208463, 0, 1'b1, -1, 3);
    chk(0, "len_beq", q.size() - n, 3);
    n = q.size();
    add_instr(32'h0100006F, 0, 1'b0, -1, 3);
    chk(0, "len_jal", q.size() - n, 4);
    n = q.size();
    add_instr(32'h0000007F, 0, 1'b0, -1, 20);
    chk(0, "len_bad", q.size() - n, 23);
    n = q.size();
    add_instr(32'h0020A023, 99, 1'b0, -1, 20);
    chk(0, "len_sw_to", q.size() - n, 39);
    n = q.size();
    add_instr(32'h0020A023, 99, 1'b0, 2, 3);
    chk(0, "len_sw_rst", q.size() - n, 6);
    n = q.size();
    add_instr(32'h0020A023, 14, 1'b0, -1, 3);
    chk(0, "len_sw_w14", q.size() - n, 18);
    for (int i = 0; i < 250; i++) begin
      ir = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: ir[6:0] = 7'h33;
        1: ir[6:0] = 7'h13;
        2: ir[6:0] = 7'h03;
        3: ir[6:0] = 7'h23;
        4: ir[6:0] = 7'h63;
        5: ir[6:0] = 7'h6F;
        6: ir[6:0] = 7'h67;
        7: ir[6:0] = 7'h37;
        8: ir[6:0] = 7'h17;
        default:
          ir[6:0] = ($urandom_range(0, 3) == 0) ? 7'h0B : 7'h13;
      endcase
      if ($urandom_range(0, 5) == 0) ir[11:7] = 5'd0;
      sel = $urandom_range(0, 9);
      if (sel < 6) w = sel;
      else if (sel < 8) w = 14;
      else if (sel == 8) w = 99;
      else w = 1;
      ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1;
      add_instr(ir, w, 1'($urandom), ra, 3);
    end
    guard = 0;
    while (q.size() != 0 && guard < 90000) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d records left, expected 0", q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
